// File: rtl/max7219_ctrl.sv
// ============================================================================
// max7219_ctrl : serial transmit controller for a daisy chain of MAX7219s
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module max7219_ctrl #(
  parameter int G_MAX_NB  = 2,
  parameter int G_CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [16*G_MAX_NB-1:0]  i_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_max7219_clk,
  output logic                    o_max7219_data,
  output logic                    o_max7219_load
);

  localparam int c_nbits = 16 * G_MAX_NB;
  localparam int c_div_w = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
  localparam int c_bit_w = $clog2(c_nbits);

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(G_CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_nbits - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_load  = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [c_nbits-1:0] shift_q, shift_d;
  logic [c_div_w-1:0] div_cnt_q, div_cnt_d;
  logic [c_bit_w-1:0] bit_cnt_q, bit_cnt_d;
  logic               phase_q, phase_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_q, sclk_d;
  logic               sdata_q, sdata_d;
  logic               load_q, load_d;
  logic               w_phase_end;

  assign w_phase_end = (div_cnt_q == c_div_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      load_q    <= load_d;
    end
  end

  // phase_q: 0 = serial clock low half, 1 = high half; LOAD reuses both halves
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    case (state_q)
      c_st_idle: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        phase_d   = 1'b0;
        if (i_start) begin
          shift_d = i_data;
          state_d = c_st_shift;
        end
      end
      c_st_shift: begin
        if (w_phase_end) begin
          div_cnt_d = '0;
          phase_d   = ~phase_q;
          if (phase_q) begin
            shift_d   = {shift_q[c_nbits-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == c_bit_last) begin
              bit_cnt_d = '0;
              state_d   = c_st_load;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      c_st_load: begin
        if (w_phase_end) begin
          div_cnt_d = '0;
          phase_d   = ~phase_q;
          if (phase_q) begin
            state_d = c_st_done;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with it
  always_comb begin
    busy_d  = (state_d == c_st_shift) || (state_d == c_st_load);
    done_d  = (state_d == c_st_done);
    sclk_d  = (state_d == c_st_shift) && phase_d;
    sdata_d = (state_d == c_st_shift) && shift_d[c_nbits-1];
    load_d  = (state_d == c_st_load);
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_max7219_clk  = sclk_q;
  assign o_max7219_data = sdata_q;
  assign o_max7219_load = load_q;

endmodule

`default_nettype wire

// File: tb/tb_max7219_ctrl.sv
// ============================================================================
// tb_max7219_ctrl : directed bench for max7219_ctrl (2x4 and 1x1 configs)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_max7219_ctrl;

  localparam int MAXC = 400;

  typedef struct {
    string    name;
    int       cyc;
    logic [4:0] exp; // {busy, load, done, sclk, sdata}
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] i_data;

  logic a_busy, a_done, a_clk, a_dat, a_load;
  logic b_busy, b_done, b_clk, b_dat, b_load;

  logic sbusy_s [0:MAXC];
  logic sload_s [0:MAXC];
  logic sdone_s [0:MAXC];
  logic sclk_s  [0:MAXC];
  logic sdat_s  [0:MAXC];

  int n_vec;
  int n_bad;

  vec_t vecs [15];

  max7219_ctrl #(.G_MAX_NB(2), .G_CLK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_data(i_data),
    .o_busy(a_busy), .o_done(a_done), .o_max7219_clk(a_clk),
    .o_max7219_data(a_dat), .o_max7219_load(a_load)
  );

  max7219_ctrl #(.G_MAX_NB(1), .G_CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_data(i_data[15:0]),
    .o_busy(b_busy), .o_done(b_done), .o_max7219_clk(b_clk),
    .o_max7219_data(b_dat), .o_max7219_load(b_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input int sel, input int c);
    if (sel == 0) begin
      sbusy_s[c] = a_busy; sload_s[c] = a_load; sdone_s[c] = a_done;
      sclk_s[c]  = a_clk;  sdat_s[c]  = a_dat;
    end else begin
      sbusy_s[c] = b_busy; sload_s[c] = b_load; sdone_s[c] = b_done;
      sclk_s[c]  = b_clk;  sdat_s[c]  = b_dat;
    end
  endtask

  // Called just after a falling edge with the selected DUT idle; cycle 0 is the accept cycle
  task automatic run(input int sel, input logic [31:0] d, input int ncyc,
                     input int p1, input int p2, input int hold_from);
    logic pulse;
    i_data = d;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    sample(sel, 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sample(sel, c);
      pulse = (c == p1) || (c == p2) || (c >= hold_from);
      if (c == p1 || c == p2) i_data = ~d;
      if (sel == 0) start_a = pulse; else start_b = pulse;
    end
  endtask

  task automatic analyse(input string tag, input int nb, input int dv, input logic [63:0] exp_frame);
    int L, rises, loads, dones, busys, first_load, done_at, clk_bad, viol;
    logic [63:0] f, mask;
    logic exp_clk;
    L = 32*nb*dv + 2*dv + 1;
    rises = 0; loads = 0; dones = 0; busys = 0; first_load = -1; done_at = -1;
    clk_bad = 0; viol = 0; f = '0;
    mask = (64'h1 << (16*nb)) - 64'h1;
    for (int c = 1; c <= L + 1; c++) begin
      if (sclk_s[c] === 1'b1 && sclk_s[c-1] === 1'b0) begin
        rises++;
        f = {f[62:0], sdat_s[c]};
        for (int k = c - dv; k <= c + dv - 1; k++)
          if (sdat_s[k] !== sdat_s[c]) viol++;
      end
      if (c > 1 && sdat_s[c] !== sdat_s[c-1] && !(sclk_s[c-1] === 1'b1 && sclk_s[c] === 1'b0))
        viol++;
      exp_clk = (((c - 1) % (2*dv)) >= dv);
      if (c <= 32*nb*dv && sclk_s[c] !== exp_clk) clk_bad++;
      if (sload_s[c] === 1'b1) begin loads++; if (first_load < 0) first_load = c; end
      if (sdone_s[c] === 1'b1) begin dones++; done_at = c; end
      if (sbusy_s[c] === 1'b1) busys++;
    end
    check({tag, " rising_edges"}, 64'(rises), 64'(16*nb));
    check({tag, " frame"}, f & mask, exp_frame);
    check({tag, " sclk_waveform_errs"}, 64'(clk_bad), 64'd0);
    check({tag, " data_stability_errs"}, 64'(viol), 64'd0);
    check({tag, " load_cycles"}, 64'(loads), 64'(2*dv));
    check({tag, " first_load_cycle"}, 64'(first_load), 64'(L - 2*dv));
    check({tag, " done_pulses"}, 64'(dones), 64'd1);
    check({tag, " done_cycle"}, 64'(done_at), 64'(L));
    check({tag, " busy_cycles"}, 64'(busys), 64'(L - 1));
  endtask

  initial begin
    int quiet_load, quiet_done, quiet_busy;
    n_vec = 0; n_bad = 0;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; i_data = '0;

    //                name               cyc   {busy,load,done,sclk,sdat}
    vecs[0]  = '{"idle_c0",      0,   5'b00000};
    vecs[1]  = '{"shift_entry",  1,   5'b10000};
    vecs[2]  = '{"low_end",      4,   5'b10000};
    vecs[3]  = '{"first_rise",   5,   5'b10010};
    vecs[4]  = '{"high_end",     8,   5'b10010};
    vecs[5]  = '{"bit1_low",     9,   5'b10000};
    vecs[6]  = '{"bit3_high",    32,  5'b10010};
    vecs[7]  = '{"bit4_data1",   33,  5'b10001};
    vecs[8]  = '{"last_bit_hi",  253, 5'b10011};
    vecs[9]  = '{"last_cycle",   256, 5'b10011};
    vecs[10] = '{"load_first",   257, 5'b11000};
    vecs[11] = '{"load_last",    264, 5'b11000};
    vecs[12] = '{"done",         265, 5'b00100};
    vecs[13] = '{"idle_after",   266, 5'b00000};
    vecs[14] = '{"relaunch",     267, 5'b10001};

    #2 rst = 1'b1;
    #1;
    check("reset_a", {a_busy, a_load, a_done, a_clk, a_dat}, 5'b0);
    check("reset_b", {b_busy, b_load, b_done, b_clk, b_dat}, 5'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Default config, re-pulses at 50 and 264, then i_start held from 265
    run(0, 32'h0C01_0A0F, 270, 50, 264, 265);
    start_a = 1'b0;
    for (int i = 0; i < 15; i++)
      check(vecs[i].name, {sbusy_s[vecs[i].cyc], sload_s[vecs[i].cyc], sdone_s[vecs[i].cyc],
                           sclk_s[vecs[i].cyc], sdat_s[vecs[i].cyc]}, vecs[i].exp);
    analyse("def", 2, 4, 64'h0C01_0A0F);

    // Relaunched transfer began at 267; go to bit 10 (cycles 347..354) and reset mid-cycle
    repeat (80) @(negedge clk);
    check("busy_before_rst", a_busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_outputs", {a_busy, a_load, a_done, a_clk, a_dat}, 5'b0);
    @(negedge clk); @(negedge clk);
    check("held_rst_outputs", {a_busy, a_load, a_done, a_clk, a_dat}, 5'b0);
    rst = 1'b0;
    quiet_load = 0; quiet_done = 0; quiet_busy = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (a_load !== 1'b0) quiet_load++;
      if (a_done !== 1'b0) quiet_done++;
      if (a_busy !== 1'b0) quiet_busy++;
    end
    check("aborted_load_cycles", 64'(quiet_load), 64'd0);
    check("aborted_done_cycles", 64'(quiet_done), 64'd0);
    check("aborted_busy_cycles", 64'(quiet_busy), 64'd0);

    run(0, 32'h0F00_0F00, 270, -1, -1, 100000);
    start_a = 1'b0;
    analyse("post_rst", 2, 4, 64'h0F00_0F00);

    // Minimal config: one device, divider 1
    @(negedge clk);
    run(1, 32'h0000_0901, 40, -1, -1, 100000);
    start_b = 1'b0;
    check("b_c1_low",   {sbusy_s[1], sclk_s[1]},  2'b10);
    check("b_c2_high",  {sbusy_s[2], sclk_s[2]},  2'b11);
    check("b_c33_load", {sload_s[33], sbusy_s[33], sclk_s[33]}, 3'b110);
    check("b_c35_done", {sdone_s[35], sbusy_s[35], sload_s[35]}, 3'b100);
    analyse("min", 1, 1, 64'h0901);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
